trg_event_framer: RTL and testbench

//  Sits directly downstream of the minimum-trigger stage. Packs each triggered run of ADC beats into one
//  AXI4-Stream frame: header (time stamp, baseline, threshold), data beats, footer (beat count, overflow flag).

---
 rtl/trg_event_framer_if.sv | 30 +++
 rtl/trg_event_framer.sv | 249 ++++++++++++++++++++++++
 tb/tb_trg_event_framer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trg_event_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : trg_event_framer_if
//  Brief    : AXI4-Stream master bus carrying the framed trigger events
//             (header, data beats, footer) toward the DMA/packet stage.
//  Revision : 1.0  initial release
// ============================================================================
interface trg_event_framer_if #(
    parameter int TDATA_WIDTH = 128
);
    logic [TDATA_WIDTH-1:0] M_AXIS_TDATA;
    logic                   M_AXIS_TVALID;
    logic                   M_AXIS_TREADY;
    logic                   M_AXIS_TLAST;

    modport master (
        output M_AXIS_TDATA,
        output M_AXIS_TVALID,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TDATA,
        input  M_AXIS_TVALID,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface
`default_nettype wire

// File: rtl/trg_event_framer.sv
`default_nettype none
// ============================================================================
//  Module   : trg_event_framer
//  Brief    : Packs each triggered run of ADC beats into one AXI4-Stream
//             frame (header, data, footer) and buffers frames in a FIFO so
//             the downstream stage can apply backpressure. Whole events that
//             cannot get room for a header are dropped and counted.
//  Revision : 1.0  initial release
// ============================================================================
module trg_event_framer #(
    parameter int TIME_STAMP_WIDTH     = 44,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int TDATA_WIDTH          = 128,   // only 128 is supported
    parameter int FIFO_DEPTH           = 64     // power of two, >= 8
) (
    input  wire logic                              AXIS_ACLK,
    input  wire logic                              AXIS_ARESET,
    input  wire logic                              TRIGGERED,
    input  wire logic                              VALID,
    input  wire logic [TDATA_WIDTH-1:0]            DATA,
    input  wire logic [TIME_STAMP_WIDTH-1:0]       TIME_STAMP,
    input  wire logic [ADC_RESOLUTION_WIDTH-1:0]   BASELINE_WHEN_HIT,
    input  wire logic [ADC_RESOLUTION_WIDTH:0]     THRESHOLD_WHEN_HIT,
    trg_event_framer_if.master                     m_axis,
    output logic [15:0]                            DROP_COUNT,
    output logic                                   FIFO_FULL
);

    localparam int              c_AW      = $clog2(FIFO_DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam int              c_WW      = TDATA_WIDTH + 1;   // data + last
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(FIFO_DEPTH);
    localparam logic [7:0]      c_HDR_TAG = 8'hAA;
    localparam logic [7:0]      c_FTR_TAG = 8'h55;
    localparam int              c_TS_LSB  = 72;
    localparam int              c_BL_LSB  = 60;
    localparam int              c_TH_LSB  = 47;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BODY   = 2'd1,
        S_FOOTER = 2'd2,
        S_SKIP   = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    w_trig_in;
    logic [TDATA_WIDTH-1:0]  r_d_data;
    logic                    r_d_trig;
    logic [15:0]             r_beat_cnt;
    logic                    r_ovf;
    logic [15:0]             r_drop_count;

    // Occupancy counts every word held by the block, including the one parked
    // in the output register, so FIFO_DEPTH is the total buffering capacity.
    logic [c_CW-1:0]         r_occ;
    logic [c_CW-1:0]         w_free;
    logic                    w_room3;
    logic                    w_room2;

    logic [c_WW-1:0]         r_mem [FIFO_DEPTH];
    logic [c_CW-1:0]         r_wr_ptr;
    logic [c_CW-1:0]         r_rd_ptr;
    logic                    w_ram_empty;
    logic                    w_wr_en;
    logic [c_WW-1:0]         w_wr_word;
    logic [TDATA_WIDTH-1:0]  w_header;
    logic [TDATA_WIDTH-1:0]  w_footer;

    logic [TDATA_WIDTH-1:0]  r_tdata;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic                    w_out_load;
    logic                    w_out_fire;
    logic                    w_ram_rd;

    assign w_trig_in   = TRIGGERED & VALID;
    assign w_free      = c_DEPTH - r_occ;
    assign w_room3     = (w_free >= c_CW'(3));
    assign w_room2     = (w_free >= c_CW'(2));
    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
    assign w_out_fire  = r_tvalid & m_axis.M_AXIS_TREADY;
    assign w_out_load  = ~r_tvalid | m_axis.M_AXIS_TREADY;
    assign w_ram_rd    = w_out_load & ~w_ram_empty;

    assign m_axis.M_AXIS_TDATA  = r_tdata;
    assign m_axis.M_AXIS_TVALID = r_tvalid;
    assign m_axis.M_AXIS_TLAST  = r_tlast;
    assign DROP_COUNT           = r_drop_count;
    assign FIFO_FULL            = (r_occ == c_DEPTH);

    // Header uses the live hit metadata; footer uses the running beat count.
    always_comb begin
        w_header                                        = '0;
        w_header[TDATA_WIDTH-1 -: 8]                    = c_HDR_TAG;
        w_header[c_TS_LSB +: TIME_STAMP_WIDTH]          = TIME_STAMP;
        w_header[c_BL_LSB +: ADC_RESOLUTION_WIDTH]      = BASELINE_WHEN_HIT;
        w_header[c_TH_LSB +: ADC_RESOLUTION_WIDTH + 1]  = THRESHOLD_WHEN_HIT;
        w_footer                                        = '0;
        w_footer[TDATA_WIDTH-1 -: 8]                    = c_FTR_TAG;
        w_footer[TDATA_WIDTH-9 -: 16]                   = r_beat_cnt;
        w_footer[TDATA_WIDTH-25]                        = r_ovf;
    end

    // Decode which word (if any) the framer pushes into the FIFO this cycle.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_word = '0;
        case (r_state)
            S_IDLE: begin
                if (w_trig_in && w_room3) begin
                    w_wr_en   = 1'b1;
                    w_wr_word = {1'b0, w_header};
                end
            end
            S_BODY: begin
                // Keeping one slot spare guarantees the footer always fits.
                if (r_d_trig && w_room2) begin
                    w_wr_en   = 1'b1;
                    w_wr_word = {1'b0, r_d_data};
                end
            end
            S_FOOTER: begin
                w_wr_en   = 1'b1;
                w_wr_word = {1'b1, w_footer};
            end
            default: begin
                w_wr_en   = 1'b0;
            end
        endcase
    end

    // Input stage: one register delay lets the header go out ahead of beat 0.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_d_data <= '0;
            r_d_trig <= 1'b0;
        end else begin
            r_d_data <= DATA;
            r_d_trig <= w_trig_in;
        end
    end

    // Framing state machine: beat counting, overflow flag and drop counter.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_state      <= S_IDLE;
            r_beat_cnt   <= '0;
            r_ovf        <= 1'b0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trig_in) begin
                        if (w_room3) begin
                            r_beat_cnt <= '0;
                            r_ovf      <= 1'b0;
                            r_state    <= S_BODY;
                        end else begin
                            if (r_drop_count != 16'hFFFF) begin
                                r_drop_count <= r_drop_count + 16'd1;
                            end
                            r_state <= S_SKIP;
                        end
                    end
                end
                S_BODY: begin
                    if (r_d_trig) begin
                        if (w_room2) begin
                            if (r_beat_cnt != 16'hFFFF) begin
                                r_beat_cnt <= r_beat_cnt + 16'd1;
                            end
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    if (!w_trig_in) begin
                        r_state <= S_FOOTER;
                    end
                end
                S_FOOTER: begin
                    // A trigger landing on the footer cycle has no header slot.
                    if (w_trig_in) begin
                        if (r_drop_count != 16'hFFFF) begin
                            r_drop_count <= r_drop_count + 16'd1;
                        end
                        r_state <= S_SKIP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (!w_trig_in) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge AXIS_ACLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_wr_word;
        end
    end

    // FIFO pointers and total occupancy (RAM plus output register).
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_CW'(1);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + c_CW'(1);
            end
            case ({w_wr_en, w_out_fire})
                2'b10:   r_occ <= r_occ + c_CW'(1);
                2'b01:   r_occ <= r_occ - c_CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Registered AXIS output: refills when empty or when the word is taken.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (w_out_load) begin
            if (!w_ram_empty) begin
                {r_tlast, r_tdata} <= r_mem[r_rd_ptr[c_AW-1:0]];
                r_tvalid           <= 1'b1;
            end else begin
                r_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trg_event_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trg_event_framer
//  Brief    : Scoreboard bench for trg_event_framer. A word-budget reference
//             model predicts every frame word; a monitor pops and compares on
//             each AXIS handshake and watches stall stability.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trg_event_framer;

    localparam int DEPTH = 16;

    logic         clk;
    logic         AXIS_ARESET;
    logic         TRIGGERED;
    logic         VALID;
    logic [127:0] DATA;
    logic [43:0]  TIME_STAMP;
    logic [11:0]  BASELINE_WHEN_HIT;
    logic [12:0]  THRESHOLD_WHEN_HIT;
    logic [15:0]  DROP_COUNT;
    logic         FIFO_FULL;

    trg_event_framer_if #(.TDATA_WIDTH(128)) m_axis ();

    trg_event_framer #(
        .TIME_STAMP_WIDTH     (44),
        .ADC_RESOLUTION_WIDTH (12),
        .TDATA_WIDTH          (128),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .AXIS_ACLK          (clk),
        .AXIS_ARESET        (AXIS_ARESET),
        .TRIGGERED          (TRIGGERED),
        .VALID              (VALID),
        .DATA               (DATA),
        .TIME_STAMP         (TIME_STAMP),
        .BASELINE_WHEN_HIT  (BASELINE_WHEN_HIT),
        .THRESHOLD_WHEN_HIT (THRESHOLD_WHEN_HIT),
        .m_axis             (m_axis),
        .DROP_COUNT         (DROP_COUNT),
        .FIFO_FULL          (FIFO_FULL)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [128:0] word;
        int           cyc;      // exact expected cycle, or -1
    } exp_t;

    exp_t         exp_q[$];
    logic [128:0] seen_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           wr_cnt   = 0;
    int           hs_cnt   = 0;
    bit           started  = 0;
    bit           exact_mode = 0;

    // Reference model: words promised to the FIFO vs words taken downstream.
    bit           m_framing, m_footer_due, m_skip, m_ovf, p_trig;
    int           m_cnt, m_drops;
    logic [127:0] p_data;
    logic [43:0]  last_ts;
    logic [11:0]  last_bl;
    logic [12:0]  last_th;

    task automatic check(input string nm, input logic [128:0] act, input logic [128:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_word(input logic [128:0] w);
        exp_t e;
        e.word = w;
        e.cyc  = exact_mode ? cyc + 2 : -1;
        exp_q.push_back(e);
        wr_cnt++;
    endfunction

    function automatic logic [128:0] footer_word(input int cnt, input bit ovf);
        return {1'b1, 8'h55, 16'(cnt), ovf, 103'h0};
    endfunction

    task automatic step(input bit trg, input bit vld, input logic [127:0] d,
                        input bit rdy, input bit rst_i);
        bit tin;
        int free;
        @(posedge clk);
        #1;
        cyc++;
        if (started) begin
            check("drop_count", 129'(DROP_COUNT), 129'(m_drops));
            check("fifo_full", 129'(FIFO_FULL), 129'((wr_cnt - hs_cnt) == DEPTH));
        end
        started            = 1;
        TRIGGERED          = trg;
        VALID              = vld;
        DATA               = d;
        TIME_STAMP         = 44'({$urandom, $urandom});
        BASELINE_WHEN_HIT  = 12'($urandom);
        THRESHOLD_WHEN_HIT = 13'($urandom);
        last_ts            = TIME_STAMP;
        last_bl            = BASELINE_WHEN_HIT;
        last_th            = THRESHOLD_WHEN_HIT;
        AXIS_ARESET        = rst_i;
        m_axis.M_AXIS_TREADY = rst_i ? 1'b0 : rdy;
        if (rst_i) begin
            m_framing = 0; m_footer_due = 0; m_skip = 0; m_ovf = 0; p_trig = 0;
            m_cnt = 0; m_drops = 0; wr_cnt = 0; hs_cnt = 0; p_data = '0;
            exp_q.delete();
        end else begin
            tin  = trg & vld;
            free = DEPTH - (wr_cnt - hs_cnt);
            if (m_skip) begin
                if (!tin) m_skip = 0;
            end else if (m_footer_due) begin
                push_word(footer_word(m_cnt, m_ovf));
                m_footer_due = 0;
                if (tin) begin
                    if (m_drops < 65535) m_drops++;
                    m_skip = 1;
                end
            end else if (m_framing) begin
                if (p_trig) begin
                    if (free >= 2) begin
                        push_word({1'b0, p_data});
                        if (m_cnt < 65535) m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (!tin) begin
                    m_framing    = 0;
                    m_footer_due = 1;
                end
            end else if (tin) begin
                if (free >= 3) begin
                    push_word({1'b0, 8'hAA, 4'h0, TIME_STAMP, BASELINE_WHEN_HIT,
                               THRESHOLD_WHEN_HIT, 47'h0});
                    m_cnt     = 0;
                    m_ovf     = 0;
                    m_framing = 1;
                end else begin
                    if (m_drops < 65535) m_drops++;
                    m_skip = 1;
                end
            end
            p_trig = tin;
            p_data = d;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_framing || m_footer_due) && k < budget) begin
            step(0, 0, rnd128(), 1, 0);
            k++;
        end
        check("drain_done", 129'(exp_q.size()), 129'(0));
        step(0, 0, rnd128(), 1, 0);
    endtask

    // Monitor: handshake scoreboard, stall stability and post-reset values.
    logic [128:0] pw;
    bit           pv, pr, after_rst;
    exp_t         got;
    initial begin
        pv = 0; pr = 0; after_rst = 0; pw = '0;
        forever begin
            @(negedge clk);
            if (AXIS_ARESET === 1'b1) begin
                after_rst = 1;
                pv        = 0;
            end else begin
                if (after_rst) begin
                    check("reset_tvalid", 129'(m_axis.M_AXIS_TVALID), 129'(0));
                    check("reset_tdata_tlast", {m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA}, 129'(0));
                    after_rst = 0;
                end
                if (pv && !pr) begin
                    check("stall_tvalid", 129'(m_axis.M_AXIS_TVALID), 129'(1));
                    check("stall_word", {m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA}, pw);
                end
                if (m_axis.M_AXIS_TVALID === 1'b1 && m_axis.M_AXIS_TREADY === 1'b1) begin
                    hs_cnt++;
                    seen_q.push_back({m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA});
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h expected none (cycle %0d)",
                                 {m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA}, cyc);
                    end else begin
                        got = exp_q.pop_front();
                        check("frame_word", {m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA}, got.word);
                        if (got.cyc >= 0) check("latency", 129'(cyc), 129'(got.cyc));
                    end
                end
                pv = m_axis.M_AXIS_TVALID;
                pr = m_axis.M_AXIS_TREADY;
                pw = {m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TDATA};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [127:0] t1_data [3];
    logic [43:0]  t1_ts;
    logic [11:0]  t1_bl;
    logic [12:0]  t1_th;
    int           len, gap, rp;

    initial begin
        AXIS_ARESET = 1; TRIGGERED = 0; VALID = 0; DATA = '0;
        TIME_STAMP = '0; BASELINE_WHEN_HIT = '0; THRESHOLD_WHEN_HIT = '0;
        m_axis.M_AXIS_TREADY = 0;

        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, rnd128(), 1, 0);
        step(0, 0, rnd128(), 1, 0);

        // 1: 3-beat event, flowing output, exact latency
        seen_q.delete();
        exact_mode = 1;
        for (int i = 0; i < 3; i++) begin
            t1_data[i] = rnd128();
            step(1, 1, t1_data[i], 1, 0);
            if (i == 0) begin
                t1_ts = last_ts; t1_bl = last_bl; t1_th = last_th;
            end
        end
        drain(40);
        exact_mode = 0;
        check("t1_words", 129'(seen_q.size()), 129'(5));
        check("t1_header", seen_q[0], {1'b0, 8'hAA, 4'h0, t1_ts, t1_bl, t1_th, 47'h0});
        for (int i = 0; i < 3; i++) check("t1_beat", seen_q[i+1], {1'b0, t1_data[i]});
        check("t1_footer", seen_q[4], {1'b1, 8'h55, 16'd3, 1'b0, 103'h0});

        // 2: 10-beat event with a 20-cycle stall
        seen_q.delete();
        for (int i = 0; i < 10; i++) step(1, 1, rnd128(), 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, rnd128(), 0, 0);
        drain(60);
        check("t2_words", 129'(seen_q.size()), 129'(12));
        check("t2_footer", seen_q[11], {1'b1, 8'h55, 16'd10, 1'b0, 103'h0});

        // 3: overfill while stalled
        seen_q.delete();
        for (int i = 0; i < DEPTH + 2; i++) step(1, 1, rnd128(), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, rnd128(), 0, 0);
        check("t3_fifo_full", 129'(FIFO_FULL), 129'(1));

        // 4: new trigger while still full is dropped whole
        for (int i = 0; i < 3; i++) step(1, 1, rnd128(), 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, rnd128(), 0, 0);
        check("t4_drop_count", 129'(DROP_COUNT), 129'(1));
        check("t4_fifo_full", 129'(FIFO_FULL), 129'(1));
        drain(80);
        check("t3_words", 129'(seen_q.size()), 129'(DEPTH));
        check("t3_footer", seen_q[DEPTH-1], {1'b1, 8'h55, 16'(DEPTH - 2), 1'b1, 103'h0});

        // 5: second event one low beat after the first lands on the footer
        seen_q.delete();
        for (int i = 0; i < 4; i++) step(1, 1, rnd128(), 1, 0);
        step(0, 1, rnd128(), 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, rnd128(), 1, 0);
        drain(40);
        check("t5_words", 129'(seen_q.size()), 129'(6));
        check("t5_drop_count", 129'(DROP_COUNT), 129'(2));

        // 6: reset in the middle of a frame
        for (int i = 0; i < 3; i++) step(1, 1, rnd128(), 1, 0);
        step(0, 0, rnd128(), 1, 1);
        seen_q.delete();
        step(0, 0, rnd128(), 1, 0);
        step(0, 0, rnd128(), 1, 0);
        check("t6_drop_count", 129'(DROP_COUNT), 129'(0));
        for (int i = 0; i < 2; i++) step(1, 1, rnd128(), 1, 0);
        drain(40);
        check("t6_words", 129'(seen_q.size()), 129'(4));
        check("t6_footer", seen_q[3], {1'b1, 8'h55, 16'd2, 1'b0, 103'h0});

        // Randomized events, gaps, VALID dropouts and backpressure
        for (int ev = 0; ev < 90; ev++) begin
            len = $urandom_range(1, 12);
            gap = $urandom_range(0, 4);
            rp  = $urandom_range(0, 3);
            for (int i = 0; i < len; i++)
                step(1, ($urandom_range(0, 9) != 0), rnd128(), ($urandom_range(0, 3) < rp), 0);
            for (int i = 0; i < gap; i++)
                step(($urandom_range(0, 1) == 1) && (i == gap), 1'($urandom), rnd128(),
                     ($urandom_range(0, 3) < rp), 0);
        end
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
